// File: rtl/regfile_arbiter.sv
// Round-robin arbiter that serializes requester reads/writes onto a single register file port.
// Optional write protection of the low LOCK_REGS addresses is enabled by defining REGFILE_ARB_PROT_EN.
module regfile_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 4,
  parameter int RD_LAT    = 1,
  parameter int LOCK_REGS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_din,
  output logic                      rf_ren,
  output logic                      rf_wen,
  input  logic [DATA_W-1:0]         rf_dout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W:0] NREGS_C = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0] LOCK_C  = (ADDR_W+1)'(LOCK_REGS);
  localparam logic [CNT_W-1:0] WLAST_C = CNT_W'(RD_LAT-1);
`ifdef REGFILE_ARB_PROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_ptr, r_win, w_gnt_idx;
  logic               w_gnt_any;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic               r_rsp_err;
  logic [CNT_W-1:0]   r_wcnt;
  logic               w_in_range, w_prot, w_err;

  logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      w_wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // Search descends so the lowest offset from pointer+1 is the last (winning) assignment.
  always_comb begin
    logic [IDX_W-1:0] w_cand;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      if (req_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_in_range = ({1'b0, r_addr} < NREGS_C);
  assign w_prot     = PROT_EN && r_we && (r_win != '0) && ({1'b0, r_addr} < LOCK_C);
  assign w_err      = !w_in_range || w_prot;

  assign rf_addr   = r_addr;
  assign rf_din    = r_wdata;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    rf_ren    = 1'b0;
    rf_wen    = 1'b0;
    case (r_state)
      S_IDLE: if (w_gnt_any) begin
        req_ready[w_gnt_idx] = 1'b1;
        w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_err) begin
          w_next = S_RESP;
        end else if (r_we) begin
          rf_wen = 1'b1;
          w_next = S_RESP;
        end else begin
          rf_ren = 1'b1;
          w_next = S_WAIT;
        end
      end
      S_WAIT: if (r_wcnt == WLAST_C) w_next = S_RESP;
      S_RESP: begin
        rsp_valid[r_win] = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Strobes are suppressed while reset is held so an in-flight transaction is simply dropped.
    if (rst) begin
      req_ready = '0;
      rsp_valid = '0;
      rf_ren    = 1'b0;
      rf_wen    = 1'b0;
      w_next    = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= IDX_W'(NUM_REQ-1);
      r_win       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wcnt      <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_gnt_any) begin
        r_ptr   <= w_gnt_idx;
        r_win   <= w_gnt_idx;
        r_we    <= req_we[w_gnt_idx];
        r_addr  <= w_addr_arr[w_gnt_idx];
        r_wdata <= w_wdata_arr[w_gnt_idx];
      end
      if (r_state == S_ISSUE) begin
        r_wcnt <= '0;
        if (w_err || r_we) begin
          r_rsp_rdata <= '0;
          r_rsp_err   <= w_err;
        end
      end else if (r_state == S_WAIT) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (r_wcnt == WLAST_C) begin
          r_rsp_rdata <= rf_dout;
          r_rsp_err   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: vector table for single transactions plus reset/contention sequences.
module tb_regfile_arbiter;
  localparam int NR = 2, AW = 8, DW = 8;
`ifdef REGFILE_ARB_PROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, rf_din;
  logic [DW-1:0]    rf_dout = 8'hEE;
  logic [AW-1:0]    rf_addr;
  logic             rsp_err, rf_ren, rf_wen;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int n_wen = 0, n_ren = 0, n_rsp = 0, n_ovl = 0;
  logic [7:0] last_waddr = '0, last_wdata = '0;
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  regfile_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(4), .RD_LAT(1), .LOCK_REGS(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rf_addr(rf_addr), .rf_din(rf_din), .rf_ren(rf_ren), .rf_wen(rf_wen),
    .rf_dout(rf_dout)
  );

  // Register file model: one-cycle read latency.
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_ren) rf_dout <= mem[rf_addr];
    if (rf_wen) mem[rf_addr] <= rf_din;
  end

  always @(negedge clk) begin
    if (rf_wen) begin n_wen++; last_waddr = rf_addr; last_wdata = rf_din; end
    if (rf_ren) n_ren++;
    if (rf_wen && rf_ren) n_ovl++;
    if (rsp_valid != '0) n_rsp++;
  end

  typedef struct {
    bit         rid;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    bit         err;
    logic [7:0] rdata;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(output logic [NR-1:0] rdy, output int t);
    rdy = '0; t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin rdy = req_ready; t = cyc; break; end
    end
  endtask

  task automatic wait_rsp(output logic [NR-1:0] v, output int t);
    v = '0; t = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin v = rsp_valid; t = cyc; break; end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [NR-1:0] rdy, rv;
    int tg, tr, w0, r0;
    bit exp_wen, exp_ren;
    w0 = n_wen; r0 = n_ren;
    exp_wen = v.we && !v.err;
    exp_ren = !v.we && !v.err;
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[v.rid] = 1'b1;
    req_we[v.rid] = v.we;
    req_addr[v.rid*AW +: AW] = v.addr;
    req_wdata[v.rid*DW +: DW] = v.wdata;
    wait_ready(rdy, tg);
    chk($sformatf("v%0d_grant", idx), 32'(rdy), 32'(1) << v.rid);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(rv, tr);
    chk($sformatf("v%0d_rsp_valid", idx), 32'(rv), 32'(1) << v.rid);
    chk($sformatf("v%0d_latency", idx), 32'(tr - tg), (v.we || v.err) ? 32'd2 : 32'd3);
    chk($sformatf("v%0d_rsp_err", idx), 32'(rsp_err), 32'(v.err));
    chk($sformatf("v%0d_rsp_rdata", idx), 32'(rsp_rdata), 32'(v.rdata));
    chk($sformatf("v%0d_wen_count", idx), 32'(n_wen - w0), 32'(exp_wen));
    chk($sformatf("v%0d_ren_count", idx), 32'(n_ren - r0), 32'(exp_ren));
    if (exp_wen)
      chk($sformatf("v%0d_wr_addr_data", idx), {16'h0, last_waddr, last_wdata}, {16'h0, v.addr, v.wdata});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] rdy, rv;
    int tg, tr, r0, s0;

    vecs[0]  = '{0, 1, 8'h02, 8'h5A, 0, 8'h00};
    vecs[1]  = '{1, 0, 8'h02, 8'h00, 0, 8'h5A};
    vecs[2]  = '{0, 0, 8'h04, 8'h00, 1, 8'h00};
    vecs[3]  = '{0, 1, 8'h03, 8'hA5, 0, 8'h00};
    vecs[4]  = '{1, 0, 8'h03, 8'h00, 0, 8'hA5};
    vecs[5]  = '{1, 1, 8'h01, 8'h3C, 0, 8'h00};
    vecs[6]  = '{0, 0, 8'h01, 8'h00, 0, 8'h3C};
    vecs[7]  = '{1, 0, 8'hFF, 8'h00, 1, 8'h00};
    vecs[8]  = '{1, 1, 8'h04, 8'h77, 1, 8'h00};
    vecs[9]  = '{1, 1, 8'h00, 8'hFF, PROT, 8'h00};
    vecs[10] = '{0, 0, 8'h00, 8'h00, 0, PROT ? 8'h00 : 8'hFF};
    vecs[11] = '{0, 1, 8'h00, 8'h11, 0, 8'h00};
    vecs[12] = '{1, 0, 8'h00, 8'h00, 0, 8'h11};

    // Reset with both requesters asserting valid.
    rst = 1'b1;
    req_valid = 2'b11; req_we = 2'b00; req_wdata = '0;
    req_addr = {8'h01, 8'h00};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("reset_outputs%0d", i),
          32'({req_ready, rsp_valid, rsp_rdata, rsp_err, rf_addr, rf_din, rf_ren, rf_wen}), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention: both hold valid, six reads of addr 0..3; grants must alternate starting with 0.
    r0 = n_ren;
    for (int k = 0; k < 6; k++) begin
      wait_ready(rdy, tg);
      chk($sformatf("contend_grant%0d", k), 32'(rdy), (k % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge clk); #1;
      req_addr[(k % 2)*AW +: AW] = 8'((k + 2) % 4);
      if (k == 5) req_valid = '0;
    end
    wait_rsp(rv, tr);
    chk("contend_last_rsp", 32'(rv), 32'd2);
    chk("contend_ren_count", 32'(n_ren - r0), 32'd6);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Reset while the read is waiting on rf_dout: the response must vanish.
    @(posedge clk); #1;
    req_valid = 2'b01; req_we = 2'b00; req_addr = {8'h00, 8'h01};
    wait_ready(rdy, tg);
    chk("rstwait_grant", 32'(rdy), 32'd1);
    s0 = n_rsp;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 2'b11; req_addr = {8'h03, 8'h03};
    wait_ready(rdy, tg);
    chk("rstwait_no_rsp", 32'(n_rsp - s0), 32'd0);
    chk("rstwait_next_grant", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(rv, tr);
    chk("rstwait_rsp_valid", 32'(rv), 32'd1);
    chk("rstwait_rdata", 32'(rsp_rdata), 32'hA5);
    chk("rstwait_latency", 32'(tr - tg), 32'd3);

    repeat (3) @(negedge clk);
    chk("no_strobe_overlap", 32'(n_ovl), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Round-robin access arbiter in front of the control register file's single addr/din/dout/ren/wen port.
- Lets several requesters share the register file, for example a host bus bridge and an internal sequencing engine.
- Serializes requests into one-cycle read or write strobes and returns a per-requester response with read data and an error flag.
- Sits between the requesters and the register file; the register file itself is unchanged.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 8, register file address width.
- DATA_W, 8, register file data width.
- NUM_REGS, 4, number of implemented byte registers; addresses at or above this are out of range.
- RD_LAT, 1, register file read latency in cycles from the ren cycle to dout valid (1..4).
- LOCK_REGS, 1, number of low addresses write-protected from requesters other than 0; used only with REGFILE_ARB_PROT_EN.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_we  input  NUM_REQ  1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  packed write data, same packing.
- req_ready  output  NUM_REQ  grant/accept strobe, one-hot, one cycle.
- rsp_valid  output  NUM_REQ  response strobe, one-hot, one cycle.
- rsp_rdata  output  DATA_W  read data; shared bus, qualified by rsp_valid.
- rsp_err  output  1  error flag; qualified by rsp_valid.
- rf_addr  output  ADDR_W  register file address.
- rf_din  output  DATA_W  register file write data.
- rf_ren  output  1  register file read strobe.
- rf_wen  output  1  register file write strobe.
- rf_dout  input  DATA_W  register file read data.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; rr pointer = NUM_REQ-1, so requester 0 wins first.
- Reset mid-transaction drops the transaction: no rf strobe completes and no rsp_valid is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, pick the first valid requester searching from pointer+1 modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in that same cycle.
  - Latch we/addr/wdata and the winner index; update pointer to the winner; go to ISSUE.
  - req_ready is 0 in every other state.
- Requester rule: valid and payload stay stable until ready. A requester may keep valid high for a back-to-back request; it is re-arbitrated on the next return to IDLE.
- ISSUE (1 cycle):
  - rf_addr and rf_din driven from the latches.
  - In range, write: rf_wen=1, then go to RESP.
  - In range, read: rf_ren=1, then go to WAIT.
  - Out of range (addr >= NUM_REGS): no strobe; go to RESP with error.
- rf_addr and rf_din hold their latched values outside ISSUE. rf_wen and rf_ren are high only in ISSUE and are never high together.
- WAIT: lasts RD_LAT cycles; rf_dout is captured into the rdata register on the edge ending the last WAIT cycle; then go to RESP.
- RESP (1 cycle):
  - rsp_valid[winner]=1.
  - rsp_rdata = captured data for reads, 0 for writes and errors.
  - rsp_err = 1 on out-of-range or protection error.
  - Go to IDLE.
- Timing with grant in cycle T:
  - write response at T+2;
  - read response at T+2+RD_LAT;
  - error response at T+2.
- Throughput: one transaction per 3 cycles (write) or 3+RD_LAT cycles (read).
- rsp_rdata and rsp_err hold their values after RESP until the next RESP; consumers use rsp_valid only.
- Simultaneous requests: exactly one grant per IDLE visit; with all requesters continuously valid, grants rotate strictly 0,1,...,NUM_REQ-1.
- A requester dropping valid before ready is legal; it is simply not granted.
- Address compare is unsigned and full ADDR_W width; there is no address wrap.

Optional Feature:
- Macro: REGFILE_ARB_PROT_EN.
- Defined: a write from requester index != 0 to an address < LOCK_REGS is a protection error. No rf_wen is issued; RESP carries rsp_err=1 at T+2. Reads remain allowed.
- Undefined: no protection check; LOCK_REGS is ignored and all in-range writes are performed.

Test Plan:
- Reset: rst=1 for 2 cycles with req_valid=2'b11 -> all outputs 0 during reset; first req_ready after release is 2'b01.
- Write: req0 writes addr=2, wdata=0x5A -> rf_wen high exactly 1 cycle with rf_addr=2, rf_din=0x5A; rsp_valid=2'b01 at grant+2; rsp_err=0.
- Read: req1 reads addr=2 after the write, RD_LAT=1 -> rf_ren high 1 cycle; rsp_valid=2'b10 at grant+3; rsp_rdata=0x5A; rsp_err=0.
- Contention: both requesters hold valid for 6 transactions (reads of addr 0..3) -> grant order 0,1,0,1,0,1; no overlapping rf strobes.
- Out-of-range: req0 reads addr=4 -> no rf_ren or rf_wen; rsp_err=1 and rsp_rdata=0 at grant+2.
- Reset and protection:
  - Reset during WAIT -> no rsp_valid; FSM in IDLE; next grant goes to requester 0.
  - With REGFILE_ARB_PROT_EN defined, req1 writes addr=0, wdata=0xFF -> no rf_wen and rsp_err=1.
  - The same write without the macro -> rf_wen issued and rsp_err=0.
